// File: rtl/fpcvt_pipe.sv
// Pipelined two's-complement integer to (S, E, F) float converter; 3-cycle latency, 1/cycle throughput.
// All stages advance together whenever the output is free or being taken. FPCVT_PIPE_RNE_EN selects round-to-nearest-even.
module fpcvt_pipe #(
  parameter int IN_W = 12,
  parameter int E_W  = 3,
  parameter int F_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_s,
  output logic [E_W-1:0]  out_e,
  output logic [F_W-1:0]  out_f,
  output logic            out_sat
);

  localparam int XW   = $clog2(IN_W + 1);
  localparam int PW   = $clog2(IN_W);
  localparam int FS   = F_W + 1;
  localparam int EMAX = (1 << E_W) - 1;

  typedef struct packed {
    logic            s;
    logic [IN_W-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic           s;
    logic [XW-1:0]  e;
    logic [F_W-1:0] f;
    logic           r;
    logic           st;
  } s2_t;

  logic adv;
  logic s1_vld;
  logic s2_vld;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: sign/magnitude; the most negative input wraps to 2^(IN_W-1) as unsigned.
  always_comb begin
    s1_d.s   = in_data[IN_W-1];
    s1_d.mag = in_data[IN_W-1] ? -in_data : in_data;
  end

  // Stage 2: normalise so the leading one sits at the top of norm; the extra low
  // zero bit keeps the sticky range non-empty when F_W = IN_W-1.
  logic [PW-1:0] lead;
  logic [IN_W:0] norm;

  always_comb begin
    lead = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_q.mag[i]) lead = PW'(i);
    end
    norm   = {s1_q.mag, 1'b0} << (PW'(IN_W - 1) - lead);
    s2_d.s = s1_q.s;
    if (int'(lead) < F_W) begin
      s2_d.e  = '0;
      s2_d.f  = s1_q.mag[F_W-1:0];
      s2_d.r  = 1'b0;
      s2_d.st = 1'b0;
    end else begin
      s2_d.e  = XW'(int'(lead) - F_W + 1);
      s2_d.f  = norm[IN_W -: F_W];
      s2_d.r  = norm[IN_W-F_W];
      s2_d.st = |norm[IN_W-F_W-1:0];
    end
  end

  // Stage 3: round, renormalise on significand carry, saturate.
  logic           inc;
  logic [FS-1:0]  f_sum;
  logic [XW-1:0]  e_rnd;
  logic [F_W-1:0] f_rnd;
  logic [E_W-1:0] e_n;
  logic [F_W-1:0] f_n;
  logic           sat_n;

`ifndef FPCVT_PIPE_RNE_EN
  logic unused_st;
  assign unused_st = s2_q.st;
`endif

  always_comb begin
`ifdef FPCVT_PIPE_RNE_EN
    inc = s2_q.r & (s2_q.st | s2_q.f[0]);
`else
    inc = s2_q.r;
`endif
    f_sum = {1'b0, s2_q.f} + FS'(inc);
    if (f_sum[F_W]) begin
      f_rnd = F_W'(1) << (F_W - 1);
      e_rnd = s2_q.e + 1'b1;
    end else begin
      f_rnd = f_sum[F_W-1:0];
      e_rnd = s2_q.e;
    end
    if (int'(e_rnd) > EMAX) begin
      e_n   = E_W'(EMAX);
      f_n   = '1;
      sat_n = 1'b1;
    end else begin
      e_n   = E_W'(int'(e_rnd));
      f_n   = f_rnd;
      sat_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      s1_vld    <= in_valid;
      s1_q      <= s1_d;
      s2_vld    <= s1_vld;
      s2_q      <= s2_d;
      out_valid <= s2_vld;
      out_s     <= s2_q.s;
      out_e     <= e_n;
      out_f     <= f_n;
      out_sat   <= sat_n;
    end
  end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Self-checking bench for fpcvt_pipe at default parameters: directed conversions,
// backpressure, random traffic against an arithmetic reference, and mid-flight reset.
module tb_fpcvt_pipe;
  localparam int IN_W = 12;
  localparam int E_W  = 3;
  localparam int F_W  = 4;
  localparam int EMAX = (1 << E_W) - 1;

  typedef struct packed {
    logic           s;
    logic [E_W-1:0] e;
    logic [F_W-1:0] f;
    logic           sat;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_s;
  logic [E_W-1:0]  out_e;
  logic [F_W-1:0]  out_f;
  logic            out_sat;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_no = 0;
  bit   lat_chk = 1'b0;
  res_t exp_q[$];
  int   t_q[$];

  fpcvt_pipe #(.IN_W(IN_W), .E_W(E_W), .F_W(F_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_f(out_f), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input int s, input int e, input int f, input int sat);
    res_t r;
    r.s = s[0]; r.e = E_W'(e); r.f = F_W'(f); r.sat = sat[0];
    return r;
  endfunction

  // Reference: value = m, choose shift so the quotient has F_W bits, round the remainder.
  function automatic res_t model(input logic [IN_W-1:0] d);
    res_t r;
    int v, m, msb, sh, q, rem, half;
    bit up;
    v = $signed(d);
    r.s = (v < 0);
    m = (v < 0) ? -v : v;
    if (m < (1 << F_W)) begin
      r.e = '0; r.f = F_W'(m); r.sat = 1'b0;
      return r;
    end
    msb = 0;
    while ((m >> (msb + 1)) != 0) msb++;
    sh   = msb - F_W + 1;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = 1 << (sh - 1);
`ifdef FPCVT_PIPE_RNE_EN
    up = (rem > half) || (rem == half && (q % 2) == 1);
`else
    up = (rem >= half);
`endif
    q = q + int'(up);
    if (q == (1 << F_W)) begin
      q  = 1 << (F_W - 1);
      sh = sh + 1;
    end
    if (sh > EMAX) begin
      r.e = E_W'(EMAX); r.f = '1; r.sat = 1'b1;
    end else begin
      r.e = E_W'(sh); r.f = F_W'(q); r.sat = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at the falling edge, check outputs, account handshakes, advance.
  task automatic step(input bit iv, input logic [IN_W-1:0] d, input bit ordy,
                      input bit use_exp, input res_t e_in, output bit took);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    took = iv && in_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("result", 32'({out_s, out_e, out_f, out_sat}), 32'(exp_q[0]));
        if (!out_ready) begin
          chk("in_ready_stall", 32'(in_ready), 32'd0);
        end else begin
          if (lat_chk) chk("latency", 32'(cyc_no - t_q[0]), 32'd3);
          void'(exp_q.pop_front());
          void'(t_q.pop_front());
        end
      end
    end
    if (took) begin
      exp_q.push_back(use_exp ? e_in : model(d));
      t_q.push_back(cyc_no);
    end
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic drain();
    bit took;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(1'b0, '0, 1'b1, 1'b0, '0, took);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [IN_W-1:0] dv[7];
    res_t            ev[7];
    logic [IN_W-1:0] bv[8];
    logic [IN_W-1:0] d;
    bit              took;
    int              idx;

    dv[0] = 12'd422;  ev[0] = mk(0, 5, 13, 0);
    dv[1] = 12'hFFB;  ev[1] = mk(1, 0, 5, 0);
    dv[2] = 12'd125;  ev[2] = mk(0, 4, 8, 0);
    dv[3] = 12'd0;    ev[3] = mk(0, 0, 0, 0);
    dv[4] = 12'd2047; ev[4] = mk(0, 7, 15, 1);
    dv[5] = 12'h800;  ev[5] = mk(1, 7, 15, 1);
    dv[6] = 12'd168;
`ifdef FPCVT_PIPE_RNE_EN
    ev[6] = mk(0, 4, 10, 0);
`else
    ev[6] = mk(0, 4, 11, 0);
`endif

    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_outputs", 32'({out_s, out_e, out_f, out_sat}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed, back-to-back, no stalls: exact 3-cycle latency.
    lat_chk = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, dv[i], 1'b1, 1'b1, ev[i], took);
      chk("directed_accept", 32'(took), 32'd1);
    end
    drain();
    lat_chk = 1'b0;

    // Eight random values with a 5-cycle output stall mid-stream.
    for (int i = 0; i < 8; i++) bv[i] = IN_W'($urandom);
    idx = 0;
    for (int t = 0; t < 60 && idx < 8; t++) begin
      step(1'b1, bv[idx], !(t >= 3 && t < 8), 1'b0, '0, took);
      if (took) idx++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd8);
    drain();

    // Random traffic with random backpressure and corner values.
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 7))
        0:       d = 12'h800;
        1:       d = 12'h7FF;
        2:       d = 12'h000;
        3:       d = 12'hFFF;
        default: d = IN_W'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, 1'b0, '0, took);
    end
    drain();

    // Reset with three results in flight.
    for (int i = 0; i < 3; i++) step(1'b1, IN_W'($urandom), 1'b0, 1'b0, '0, took);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_outputs", 32'({out_s, out_e, out_f, out_sat}), 32'd0);
    exp_q.delete();
    t_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    step(1'b1, 12'd422, 1'b1, 1'b1, mk(0, 5, 13, 0), took);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
